// File: rtl/shader_loader.sv
// Serial instruction loader: receives bytes over a slow external SPI link, strobes them into
// a downstream shift memory, then rotates that memory so the first word of the program sits at position 0.
module shader_loader #(
    parameter int NUM_INSTR = 10
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       spi_cs_ni,
    input  logic       spi_sclk_i,
    input  logic       spi_mosi_i,
    input  logic       exec_shift_i,
    output logic       shift_o,
    output logic       load_o,
    output logic [7:0] instr_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int WCW = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECEIVE,
        S_ALIGN
    } state_e;

    // Two-flop synchronizers; reset values match an idle bus (cs deasserted, sclk low).
    logic [1:0] cs_sync_q;
    logic [1:0] sclk_sync_q;
    logic [1:0] mosi_sync_q;
    logic       sclk_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cs_sync_q   <= 2'b11;
            sclk_sync_q <= 2'b00;
            mosi_sync_q <= 2'b00;
            sclk_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
            cs_sync_q   <= {cs_sync_q[0], spi_cs_ni};
            sclk_sync_q <= {sclk_sync_q[0], spi_sclk_i};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
            sclk_prev_q <= sclk_sync_q[1];
        end
    end

    logic cs_high;
    logic sclk_rise;
    logic mosi_bit;

    assign cs_high   = cs_sync_q[1];
    assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
    assign mosi_bit  = mosi_sync_q[1];

    state_e           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0]   word_cnt_q, word_cnt_d;
    logic [WCW-1:0]   rot_cnt_q, rot_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       instr_q, instr_d;
    logic             loaded_q, loaded_d;
    logic             shift_q, shift_d;
    logic             load_q, load_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [7:0]       byte_next;
    logic [WCW-1:0]   rot_len;
    logic [WCW-1:0]   word_cnt_inc;

    assign byte_next    = {shreg_q[6:0], mosi_bit};
    assign rot_len      = (word_cnt_q == '0) ? '0 : WCW'(NUM_INSTR) - word_cnt_q;
    assign word_cnt_inc = (word_cnt_q == WCW'(NUM_INSTR - 1)) ? '0 : word_cnt_q + WCW'(1);

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        rot_cnt_d  = rot_cnt_q;
        shreg_d    = shreg_q;
        instr_d    = instr_q;
        loaded_d   = loaded_q;
        shift_d    = 1'b0;
        load_d     = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!cs_high) begin
                    state_d    = S_RECEIVE;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    loaded_d   = 1'b0;
                end
            end
            S_RECEIVE: begin
                // A completing byte wins over cs-high; cs is then seen on the strobe cycle
                // with the word count already including that byte.
                if (sclk_rise && bit_cnt_q == 3'd7) begin
                    shreg_d    = byte_next;
                    instr_d    = byte_next;
                    bit_cnt_d  = '0;
                    word_cnt_d = word_cnt_inc;
                    loaded_d   = 1'b1;
                    shift_d    = 1'b1;
                    load_d     = 1'b1;
                end else if (cs_high) begin
                    if (rot_len == '0) begin
                        state_d = S_IDLE;
                        done_d  = loaded_q;
                    end else begin
                        state_d   = S_ALIGN;
                        rot_cnt_d = rot_len;
                        shift_d   = 1'b1;
                    end
                end else if (sclk_rise) begin
                    shreg_d   = byte_next;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            S_ALIGN: begin
                if (rot_cnt_q <= WCW'(1)) begin
                    state_d = S_IDLE;
                    done_d  = loaded_q;
                end else begin
                    rot_cnt_d = rot_cnt_q - WCW'(1);
                    shift_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            rot_cnt_q  <= '0;
            shreg_q    <= '0;
            instr_q    <= '0;
            loaded_q   <= 1'b0;
            shift_q    <= 1'b0;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            rot_cnt_q  <= rot_cnt_d;
            shreg_q    <= shreg_d;
            instr_q    <= instr_d;
            loaded_q   <= loaded_d;
            shift_q    <= shift_d;
            load_q     <= load_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // In IDLE the execution unit owns the memory shift; otherwise only loader strobes reach it.
    assign shift_o = (state_q == S_IDLE) ? exec_shift_i : shift_q;
    assign load_o  = load_q;
    assign instr_o = instr_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_shader_loader.sv
// Bench for shader_loader: drives SPI windows and tracks a model of the downstream shift memory,
// comparing strobes, rotations, done pulses and final memory layout against arithmetic expectations.
module tb_shader_loader;

    localparam int N = 10;

    logic       clk          = 1'b0;
    logic       rst_ni       = 1'b0;
    logic       spi_cs_ni    = 1'b1;
    logic       spi_sclk_i   = 1'b0;
    logic       spi_mosi_i   = 1'b0;
    logic       exec_shift_i = 1'b0;
    logic       shift_o;
    logic       load_o;
    logic [7:0] instr_o;
    logic       busy_o;
    logic       done_o;

    int vectors     = 0;
    int miscompares = 0;
    int loads       = 0;
    int rots        = 0;
    int dones       = 0;

    logic [7:0] mem      [N];
    logic [7:0] base_mem [N];
    logic [7:0] fin_mem  [N];
    logic [7:0] exp_q [$];
    logic [7:0] win_q [$];
    logic       busy_prev = 1'b0;
    logic [7:0] fixed_b [3];

    typedef struct {
        int nbytes;
        int partial;
        int exec_hold;
        int cs_last;
        int exp_loads;
        int exp_rots;
        int exp_dones;
    } vec_t;

    vec_t vecs [9];

    shader_loader #(.NUM_INSTR(N)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .spi_cs_ni    (spi_cs_ni),
        .spi_sclk_i   (spi_sclk_i),
        .spi_mosi_i   (spi_mosi_i),
        .exec_shift_i (exec_shift_i),
        .shift_o      (shift_o),
        .load_o       (load_o),
        .instr_o      (instr_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: every shift moves words toward position 0; the last slot takes instr_o or wraps.
    always @(negedge clk) begin : monitor
        logic [7:0] first;
        if (!busy_o) check("passthru", {shift_o, load_o}, {exec_shift_i, 1'b0});
        if (rst_ni) begin
            if (busy_o && !busy_prev) begin
                base_mem = mem;
                win_q.delete();
            end
            if (!busy_o && busy_prev) fin_mem = mem;
            if (shift_o) begin
                if (load_o) begin
                    loads++;
                    if (exp_q.size() == 0) check("unexpected_load", 32'd1, 32'd0);
                    else check("strobe_instr", instr_o, exp_q.pop_front());
                end else if (busy_o) begin
                    rots++;
                end
                first = mem[0];
                for (int i = 0; i < N - 1; i++) mem[i] = mem[i + 1];
                mem[N - 1] = load_o ? instr_o : first;
            end
            if (done_o) dones++;
        end
        busy_prev = busy_o;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_busy(input logic level, input string name);
        int n = 0;
        while (busy_o !== level && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, busy_o, level);
    endtask

    task automatic spi_bit(input logic v, input bit raise_cs);
        spi_sclk_i = 1'b0;
        spi_mosi_i = v;
        wait_clk(4);
        spi_sclk_i = 1'b1;
        if (raise_cs) spi_cs_ni = 1'b1;
        wait_clk(4);
        spi_sclk_i = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b, input bit raise_cs);
        win_q.push_back(b);
        exp_q.push_back(b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i], raise_cs && i == 0);
        wait_clk(4);
    endtask

    // Final layout: last N words of (old memory ++ program), rotated so the word whose load index
    // is the largest multiple of N sits at position 0.
    task automatic check_mem();
        int k = win_q.size();
        int m;
        logic [7:0] s [$];
        logic [7:0] e;
        for (int j = 0; j < N; j++) s.push_back(base_mem[j]);
        for (int j = 0; j < k; j++) s.push_back(win_q[j]);
        m = (k == 0) ? 0 : ((k - 1) / N) * N;
        for (int j = 0; j < N; j++) begin
            e = (k == 0) ? base_mem[j] : s[k + ((N + m - k + j) % N)];
            check($sformatf("mem[%0d]", j), fin_mem[j], e);
        end
    endtask

    task automatic run_txn(input int k, input int partial, input bit exec_hold, input bit cs_last,
                           input int exp_loads, input int exp_rots, input int exp_dones,
                           input bit use_fixed);
        logic [7:0] exp_instr = instr_o;
        logic [7:0] b;
        loads = 0;
        rots  = 0;
        dones = 0;
        exp_q.delete();
        spi_cs_ni = 1'b0;
        wait_clk(6);
        exec_shift_i = exec_hold;
        for (int i = 0; i < k; i++) begin
            b = use_fixed ? fixed_b[i % 3] : 8'($urandom_range(0, 255));
            exp_instr = b;
            spi_byte(b, cs_last && i == k - 1);
        end
        for (int p = 0; p < partial; p++) spi_bit(1'($urandom_range(0, 1)), 1'b0);
        wait_clk(4);
        spi_cs_ni = 1'b1;
        wait_busy(1'b0, "txn_idle_timeout");
        exec_shift_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check($sformatf("loads k=%0d", k), loads, exp_loads);
        check($sformatf("rots k=%0d", k), rots, exp_rots);
        check($sformatf("dones k=%0d", k), dones, exp_dones);
        check($sformatf("instr_hold k=%0d", k), instr_o, exp_instr);
        check_mem();
    endtask

    initial begin
        int k;
        int p;
        bit cl;
        for (int j = 0; j < N; j++) mem[j] = 8'hA0 + 8'(j);
        fixed_b[0] = 8'h10;
        fixed_b[1] = 8'h5D;
        fixed_b[2] = 8'hF4;
        //           bytes part exec csl loads rots dones
        vecs[0] = '{3,  0, 0, 0, 3,  7, 1};
        vecs[1] = '{10, 0, 0, 0, 10, 0, 1};
        vecs[2] = '{0,  5, 0, 0, 0,  0, 0};
        vecs[3] = '{3,  3, 1, 0, 3,  7, 1};
        vecs[4] = '{12, 0, 0, 0, 12, 8, 1};
        vecs[5] = '{4,  0, 0, 1, 4,  6, 1};
        vecs[6] = '{10, 0, 1, 1, 10, 0, 1};
        vecs[7] = '{1,  2, 0, 0, 1,  9, 1};
        vecs[8] = '{0,  0, 0, 0, 0,  0, 0};

        wait_clk(3);
        check("rst_instr", instr_o, 8'h00);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_load", load_o, 1'b0);
        rst_ni = 1'b1;
        wait_clk(3);

        // Idle passthrough of execution-unit shifts.
        for (int i = 0; i < 3; i++) begin
            exec_shift_i = 1'b1;
            @(negedge clk);
            #1;
            check("idle_shift", shift_o, 1'b1);
            check("idle_load", load_o, 1'b0);
            check("idle_busy", busy_o, 1'b0);
            wait_clk(1);
        end
        exec_shift_i = 1'b0;
        #1;
        check("idle_shift_off", shift_o, 1'b0);
        wait_clk(2);

        for (int v = 0; v < 9; v++)
            run_txn(vecs[v].nbytes, vecs[v].partial, vecs[v].exec_hold != 0, vecs[v].cs_last != 0,
                    vecs[v].exp_loads, vecs[v].exp_rots, vecs[v].exp_dones, v == 0);

        for (int r = 0; r < 6; r++) begin
            k  = $urandom_range(0, 22);
            p  = $urandom_range(0, 7);
            cl = (k > 0 && p == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_txn(k, p, 1'($urandom_range(0, 1)), cl, k, (k == 0) ? 0 : (N - k % N) % N,
                    (k > 0) ? 1 : 0, 1'b0);
        end

        // cs reasserted mid-ALIGN: rotation finishes, done pulses, then a new window starts.
        loads = 0;
        rots  = 0;
        dones = 0;
        exp_q.delete();
        spi_cs_ni = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 3; i++) spi_byte(fixed_b[i], 1'b0);
        spi_cs_ni = 1'b1;
        begin
            int n = 0;
            while (rots < 2 && n < 200) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        spi_cs_ni = 1'b0;
        wait_busy(1'b0, "realign_idle_timeout");
        wait_busy(1'b1, "realign_rearm_timeout");
        check("realign_rots", rots, 7);
        check("realign_dones", dones, 1);
        wait_clk(2);
        spi_byte(8'h3C, 1'b0);
        spi_cs_ni = 1'b1;
        wait_busy(1'b0, "realign2_idle_timeout");
        repeat (3) @(negedge clk);
        #1;
        check("realign2_loads", loads, 4);
        check("realign2_rots", rots, 16);
        check("realign2_dones", dones, 2);
        check_mem();

        // Reset after 2 of 7 rotations aborts the alignment outright.
        loads = 0;
        rots  = 0;
        dones = 0;
        exp_q.delete();
        spi_cs_ni = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 3; i++) spi_byte(fixed_b[i], 1'b0);
        spi_cs_ni = 1'b1;
        begin
            int n = 0;
            while (rots < 2 && n < 200) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        check("abort_rots_before", rots, 2);
        rst_ni = 1'b0;
        #1;
        check("abort_shift", shift_o, 1'b0);
        check("abort_busy", busy_o, 1'b0);
        check("abort_done", done_o, 1'b0);
        exec_shift_i = 1'b1;
        #1;
        check("abort_follow", shift_o, 1'b1);
        exec_shift_i = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("abort_rots_after", rots, 2);
        check("abort_dones", dones, 0);
        check("abort_instr", instr_o, 8'h00);
        wait_clk(1);
        rst_ni = 1'b1;
        wait_clk(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shader_loader.md
SHADER_LOADER -- requirements
Module: shader_loader

Interface
REQ-001 SHALL have parameter NUM_INSTR, default 10, meaning depth of the downstream instruction shift memory (words).
REQ-002 SHALL have clk_i input 1: system clock, all logic on rising edge.
REQ-003 SHALL have rst_ni input 1: reset, asynchronous, active-low.
REQ-004 SHALL have spi_cs_ni input 1: external chip select, active-low, asynchronous to clk_i.
REQ-005 SHALL have spi_sclk_i input 1: external serial clock, asynchronous; data sampled on its rising edge.
REQ-006 SHALL have spi_mosi_i input 1: external serial data, MSB first.
REQ-007 SHALL have exec_shift_i input 1: shift request from execution unit (one instruction consumed).
REQ-008 SHALL have shift_o output 1: shift strobe to instruction memory.
REQ-009 SHALL have load_o output 1: with shift_o, replace last memory word by instr_o; without load_o, shift is circular.
REQ-010 SHALL have instr_o output 8: assembled instruction word.
REQ-011 SHALL have busy_o output 1: high in RECEIVE or ALIGN.
REQ-012 SHALL have done_o output 1: one-cycle pulse on completed program load.

Function
REQ-013 SHALL pass spi_cs_ni, spi_sclk_i, spi_mosi_i through 2-flop synchronizers; sclk rising edge detected from synchronized sclk vs its previous value.
REQ-014 SHALL require sclk high and low phases each >= 3 clk_i cycles; faster sclk behaviour undefined.
REQ-015 SHALL implement FSM states IDLE, RECEIVE, ALIGN.
REQ-016 IDLE: shift_o = exec_shift_i (combinational), load_o = 0, busy_o = 0; synchronized cs low -> RECEIVE, clearing bit count (3 bit) and word count (0..NUM_INSTR-1) and loaded flag.
REQ-017 RECEIVE: each detected sclk edge shifts synchronized mosi into LSB of 8-bit shift register; exec_shift_i ignored.
REQ-018 On 8th bit: instr_o <= assembled byte; shift_o = load_o = 1 for exactly the next cycle; bit count -> 0; word count increments, wrapping NUM_INSTR-1 -> 0; loaded flag set.
REQ-019 instr_o SHALL hold its value until the next completed byte.
REQ-020 Synchronized cs high in RECEIVE: partial byte (bit count != 0) discarded, no strobe; rotation count R = (NUM_INSTR - word count) mod NUM_INSTR.
REQ-021 If R = 0 -> IDLE directly; else -> ALIGN.
REQ-022 ALIGN: shift_o = 1, load_o = 0 for exactly R consecutive cycles, then IDLE; exec_shift_i, sclk edges ignored.
REQ-023 Effect: word with load index equal to largest multiple of NUM_INSTR (first word if fewer than NUM_INSTR loaded) ends at memory position 0.
REQ-024 done_o SHALL pulse one cycle on the cycle FSM enters IDLE from RECEIVE/ALIGN, only if loaded flag set; CS windows with no complete byte produce no done_o and no shifts.
REQ-025 A final-byte strobe and cs-high detection in same cycle: strobe issued, word count includes that byte in R.
REQ-026 cs low while in ALIGN: ALIGN completes, then IDLE re-enters RECEIVE on next cycle (level sensitive).

Reset
REQ-027 On rst_ni low: FSM IDLE, counters 0, shift register 0, instr_o = 8'h00, load_o = 0, busy_o = 0, done_o = 0, synchronizers reset to cs=1, sclk=0, mosi=0; shift_o follows exec_shift_i.
REQ-028 Reset mid-RECEIVE/ALIGN SHALL abort immediately with no further strobes; partial rotation not completed.

Verification
REQ-029 Idle passthrough: exec_shift_i pulsed 3 cycles -> shift_o high those 3 cycles, load_o 0, busy_o 0.
REQ-030 Load 3 bytes 0x10,0x5D,0xF4 (NUM_INSTR=10), cs high -> three load strobes with instr_o matching, then 7 cycles shift_o=1/load_o=0, one done_o pulse.
REQ-031 Load exactly 10 bytes -> 10 load strobes, no ALIGN cycles, done_o on return to IDLE.
REQ-032 cs low, 5 sclk edges, cs high -> no strobes, no shifts, no done_o, instr_o unchanged.
REQ-033 exec_shift_i held high during RECEIVE and ALIGN -> shift_o only from loader strobes/rotation.
REQ-034 rst_ni asserted mid-ALIGN after 2 of 7 rotations -> shift_o follows exec_shift_i (0) immediately, busy_o 0, no done_o.
